// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter: shares one variable-latency memory bus between the
// instruction fetch port and the data access port. Data wins over fetch, and
// a granted transaction is held until the bus completes it. mem_stall freezes
// the pipeline until the instruction word for f_pc and any pending data access
// have both completed.
// Optional feature: define ARB_WATCHDOG_EN to abandon a transaction that waits
// TIMEOUT_CYCLES cycles without bus_ready. An abandoned fetch returns a nop and
// an abandoned data access returns zero; bus_error is then set and stays set.
module pipeline_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] f_pc,
  output logic [31:0] f_inst,
  input  logic [31:0] d_address,
  input  logic [31:0] d_write_data,
  input  logic [2:0]  d_format,
  input  logic        d_read_enable,
  input  logic        d_write_enable,
  output logic [31:0] d_read_data,
  output logic        mem_stall,
  output logic        bus_request,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic        bus_write_enable,
  output logic [2:0]  bus_format,
  input  logic        bus_ready,
  input  logic [31:0] bus_read_data,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA_WAIT = 2'd1, FETCH_WAIT = 2'd2} arb_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [2:0]  FMT_WORD = 3'b010;

  arb_state_t  arb_state;
  logic [31:0] inst_q, inst_pc_q, data_q;
  logic        inst_valid_q, data_done_q;
  logic [31:0] lat_address, lat_write_data;
  logic        lat_write_enable;
  logic [2:0]  lat_format;

  logic        data_access, data_pending, inst_hit, fetch_pending;
  logic        in_idle, owner_data, active, done, timeout;
  logic        data_complete, fetch_complete, fetch_now;
  logic        inst_ok, data_ok, step;
  logic [31:0] cur_address, cur_write_data, rdata;
  logic        cur_write_enable;
  logic [2:0]  cur_format;

  // Grant, current payload, completion and step decode.
  always_comb begin
    data_access      = d_read_enable | d_write_enable;
    data_pending     = data_access & ~data_done_q;
    inst_hit         = inst_valid_q & (inst_pc_q == f_pc);
    fetch_pending    = ~inst_hit;
    in_idle          = (arb_state == IDLE);
    owner_data       = in_idle ? data_pending : (arb_state == DATA_WAIT);
    active           = in_idle ? (data_pending | fetch_pending) : 1'b1;
    cur_address      = lat_address;
    cur_write_data   = lat_write_data;
    cur_write_enable = lat_write_enable;
    cur_format       = lat_format;
    if (in_idle) begin
      if (data_pending) begin
        cur_address      = d_address;
        cur_write_data   = d_write_data;
        cur_write_enable = d_write_enable;
        cur_format       = d_format;
      end else begin
        cur_address      = f_pc;
        cur_write_data   = '0;
        cur_write_enable = 1'b0;
        cur_format       = FMT_WORD;
      end
    end
    done  = active & (bus_ready | timeout);
    rdata = bus_read_data;
    if (timeout) rdata = owner_data ? 32'h0 : NOP_INST;
    data_complete  = done & owner_data;
    fetch_complete = done & ~owner_data;
    // A completing fetch only satisfies IF if it was for the current pc
    // (after a redirect it is the stale address).
    fetch_now = fetch_complete & (cur_address == f_pc);
    inst_ok   = inst_hit | fetch_now;
    data_ok   = ~data_access | data_done_q | data_complete;
    step      = inst_ok & data_ok;
  end

  assign bus_request      = ~reset & active & ~timeout;
  assign bus_address      = cur_address;
  assign bus_write_data   = cur_write_data;
  assign bus_write_enable = cur_write_enable;
  assign bus_format       = cur_format;
  assign f_inst           = fetch_complete ? rdata : inst_q;
  assign d_read_data      = data_complete ? rdata : data_q;
  assign mem_stall        = reset | ~step;

  // Arbiter state, latched payload and the completed-result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      arb_state    <= IDLE;
      inst_valid_q <= 1'b0;
      data_done_q  <= 1'b0;
    end else begin
      case (arb_state)
        IDLE: begin
          if (active && !bus_ready) begin
            arb_state        <= data_pending ? DATA_WAIT : FETCH_WAIT;
            lat_address      <= cur_address;
            lat_write_data   <= cur_write_data;
            lat_write_enable <= cur_write_enable;
            lat_format       <= cur_format;
          end
        end
        default: if (bus_ready || timeout) arb_state <= IDLE;
      endcase
      if (data_complete) begin
        data_done_q <= 1'b1;
        if (!cur_write_enable) data_q <= rdata;
      end
      if (fetch_complete) begin
        inst_q       <= rdata;
        inst_pc_q    <= cur_address;
        inst_valid_q <= 1'b1;
      end
      // Advancing consumes both results; the bypass already showed them.
      if (step) begin
        data_done_q  <= 1'b0;
        inst_valid_q <= 1'b0;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  assign timeout = (arb_state != IDLE) && (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) && !bus_ready;

  // Count cycles spent waiting; raise the sticky error on abandonment.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      if (arb_state != IDLE && !bus_ready && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                             wait_cnt <= '0;
      if (timeout) bus_error <= 1'b1;
    end
  end
`else
  localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter. The bus returns
// 32'hC0DE0000 | address[15:0] for every read; bus_ready is driven per step.
module tb_pipeline_mem_arbiter;

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] f_pc, f_inst, d_address, d_write_data, d_read_data;
  logic [2:0]  d_format, bus_format;
  logic        d_read_enable, d_write_enable, mem_stall;
  logic        bus_request, bus_write_enable, bus_ready, bus_error;
  logic [31:0] bus_address, bus_write_data, bus_read_data;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  pipeline_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .f_pc(f_pc), .f_inst(f_inst),
    .d_address(d_address), .d_write_data(d_write_data), .d_format(d_format),
    .d_read_enable(d_read_enable), .d_write_enable(d_write_enable),
    .d_read_data(d_read_data), .mem_stall(mem_stall),
    .bus_request(bus_request), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_write_enable(bus_write_enable),
    .bus_format(bus_format), .bus_ready(bus_ready),
    .bus_read_data(bus_read_data), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  assign bus_read_data = 32'hC0DE_0000 | {16'h0, bus_address[15:0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; bus_ready = 1'b0; f_pc = 32'h0;
    d_address = '0; d_write_data = '0; d_format = 3'b010;
    d_read_enable = 1'b0; d_write_enable = 1'b0;
    tick();
    check("rst_req", bus_request, 1'b0);
    check("rst_stall", mem_stall, 1'b1);
    check("rst_err", bus_error, 1'b0);
    tick();
    check("rst_req2", bus_request, 1'b0);

    // zero-wait bus, ALU stream: one fetch per cycle, no stall
    reset = 1'b0; bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_pc = 32'(4 * i);
      #1;
      check("alu_stall", mem_stall, 1'b0);
      check("alu_inst", f_inst, 32'hC0DE_0000 | 32'(4 * i));
      check("alu_addr", bus_address, 32'(4 * i));
      check("alu_fmt", bus_format, 3'b010);
      tick();
    end

    // lw 0x100 + fetch 0x8, 3-cycle latency: data first, 5 stall cycles
    f_pc = 32'h8; d_read_enable = 1'b1; d_address = 32'h100; bus_ready = 1'b0;
    #1;
    check("lw_c1_addr", bus_address, 32'h100);
    check("lw_c1_we", bus_write_enable, 1'b0);
    check("lw_c1_stall", mem_stall, 1'b1);
    tick();
    d_address = 32'h200;
    #1;
    check("lw_c2_hold", bus_address, 32'h100);
    check("lw_c2_stall", mem_stall, 1'b1);
    tick();
    d_address = 32'h100; bus_ready = 1'b1;
    #1;
    check("lw_c3_stall", mem_stall, 1'b1);
    check("lw_c3_byp", d_read_data, 32'hC0DE_0100);
    tick();
    bus_ready = 1'b0;
    #1;
    check("lw_c4_addr", bus_address, 32'h8);
    check("lw_c4_fmt", bus_format, 3'b010);
    check("lw_c4_stall", mem_stall, 1'b1);
    tick();
    check("lw_c5_req", bus_request, 1'b1);
    check("lw_c5_stall", mem_stall, 1'b1);
    tick();
    bus_ready = 1'b1;
    #1;
    check("lw_step_stall", mem_stall, 1'b0);
    check("lw_step_data", d_read_data, 32'hC0DE_0100);
    check("lw_step_inst", f_inst, 32'hC0DE_0008);
    tick();

    // sw completing in its first cycle, then fetch 0xC
    d_read_enable = 1'b0; d_write_enable = 1'b1; d_address = 32'h104;
    d_write_data = 32'hDEAD_BEEF; d_format = 3'b001; f_pc = 32'hC;
    #1;
    check("sw_we", bus_write_enable, 1'b1);
    check("sw_fmt", bus_format, 3'b001);
    check("sw_wdata", bus_write_data, 32'hDEAD_BEEF);
    check("sw_addr", bus_address, 32'h104);
    check("sw_stall", mem_stall, 1'b1);
    tick();
    check("sw_fetch_we", bus_write_enable, 1'b0);
    check("sw_fetch_addr", bus_address, 32'hC);
    check("sw_step", mem_stall, 1'b0);
    tick();
    f_pc = 32'h10;
    #1;
    check("sw_done_clr", bus_write_enable, 1'b1);

    // redirect during FETCH_WAIT: 0x10 finishes, 0x40 refetched
    d_write_enable = 1'b0; bus_ready = 1'b0;
    #1;
    check("rd_grant", bus_address, 32'h10);
    tick();
    f_pc = 32'h40;
    #1;
    check("rd_hold", bus_address, 32'h10);
    check("rd_stall1", mem_stall, 1'b1);
    tick();
    bus_ready = 1'b1;
    #1;
    check("rd_stale", mem_stall, 1'b1);
    tick();
    bus_ready = 1'b0;
    #1;
    check("rd_refetch", bus_address, 32'h40);
    tick();
    bus_ready = 1'b1;
    #1;
    check("rd_stall_end", mem_stall, 1'b0);
    check("rd_inst", f_inst, 32'hC0DE_0040);
    tick();

    // reset during DATA_WAIT
    f_pc = 32'h44; d_read_enable = 1'b1; d_address = 32'h108; bus_ready = 1'b0;
    #1;
    check("rs_grant", bus_address, 32'h108);
    tick();
    check("rs_wait_req", bus_request, 1'b1);
    reset = 1'b1;
    #1;
    check("rs_req_lo", bus_request, 1'b0);
    tick();
    check("rs_held_req", bus_request, 1'b0);
    check("rs_held_stall", mem_stall, 1'b1);
    reset = 1'b0; d_read_enable = 1'b0;
    #1;
    check("rs_restart_req", bus_request, 1'b1);
    check("rs_restart_addr", bus_address, 32'h44);
    bus_ready = 1'b1;
    #1;
    check("rs_step", mem_stall, 1'b0);
    check("rs_inst", f_inst, 32'hC0DE_0044);
    tick();

`ifdef ARB_WATCHDOG_EN
    // stuck bus on a fetch: abandoned after TO cycles with a nop
    f_pc = 32'h80; bus_ready = 1'b0;
    #1;
    check("wd_req0", bus_request, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("wd_req", bus_request, 1'b1);
      check("wd_stall", mem_stall, 1'b1);
      tick();
    end
    check("wd_drop", bus_request, 1'b0);
    check("wd_nop", f_inst, 32'h0000_0013);
    check("wd_step", mem_stall, 1'b0);
    check("wd_err_pre", bus_error, 1'b0);
    tick();
    check("wd_err", bus_error, 1'b1);
`else
    check("no_wd_err", bus_error, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
